kitchen_timer_ctrl: RTL and testbench

Countdown controller for the kitchen timer, generating the four 7-bit segment patterns that drive the `Seven` four-digit display multiplexer. It holds an MM:SS time in BCD and runs a SET/RUN/PAUSE/DONE state machine from debounced single-cycle button pulses. It derives a one-second tick from `clk`, decrements the time while running, and raises `alarm` at zero. Outputs `c1`..`c4` connect directly to `Seven`'s `c1`..`c4`.

---
 rtl/kitchen_timer_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_kitchen_timer_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/kitchen_timer_ctrl.sv
// ============================================================================
//  Module   : kitchen_timer_ctrl
//  Brief    : MM:SS BCD countdown timer with SET/RUN/PAUSE/DONE control and
//             registered active-low seven-segment outputs.
//             Optional macro KTIMER_BLINK_EN blinks the display while in DONE.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module kitchen_timer_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [6:0] c1,
    output logic [6:0] c2,
    output logic [6:0] c3,
    output logic [6:0] c4,
    output logic       alarm,
    output logic       running
);

    localparam logic [1:0] c_st_set   = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] c_presc_max  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] c_alarm_last = AW'(ALARM_SECS - 1);
    localparam logic [6:0]    c_seg_blank  = 7'b1111111;

    logic [1:0]    r_state, w_state_nxt;
    logic [3:0]    r_min_t, r_min_o, r_sec_t, r_sec_o;
    logic [3:0]    w_min_t_nxt, w_min_o_nxt, w_sec_t_nxt, w_sec_o_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [AW-1:0] r_acnt, w_acnt_nxt;
    logic          w_tick, w_zero, w_last, w_blank;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b1111111;
        endcase
    endfunction

    assign w_tick = ((r_state == c_st_run) || (r_state == c_st_done)) && (r_presc == c_presc_max);
    assign w_zero = ({r_min_t, r_min_o, r_sec_t, r_sec_o} == 16'h0000);
    // The tick that lands on this time is the one that reaches 00:00
    assign w_last = ({r_min_t, r_min_o, r_sec_t, r_sec_o} == 16'h0001);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_set;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (btn_clear) begin
            w_state_nxt = c_st_set;
        end else begin
            case (r_state)
                c_st_set:   if (btn_start && !w_zero) w_state_nxt = c_st_run;
                c_st_run: begin
                    if (w_tick && w_last)  w_state_nxt = c_st_done;
                    else if (btn_start)    w_state_nxt = c_st_pause;
                end
                c_st_pause: if (btn_start) w_state_nxt = c_st_run;
                c_st_done: begin
                    if (btn_start || (w_tick && (r_acnt == c_alarm_last)))
                        w_state_nxt = c_st_set;
                end
                default:    w_state_nxt = c_st_set;
            endcase
        end
    end

    // Output decode
    always_comb begin
        alarm   = (r_state == c_st_done);
        running = (r_state == c_st_run);
    end

    // Time, prescaler and alarm counter next values
    always_comb begin
        w_min_t_nxt = r_min_t;
        w_min_o_nxt = r_min_o;
        w_sec_t_nxt = r_sec_t;
        w_sec_o_nxt = r_sec_o;
        w_presc_nxt = r_presc;
        w_acnt_nxt  = '0;
        if (btn_clear) begin
            w_min_t_nxt = 4'd0;
            w_min_o_nxt = 4'd0;
            w_sec_t_nxt = 4'd0;
            w_sec_o_nxt = 4'd0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                c_st_set: begin
                    w_presc_nxt = '0;
                    if (btn_min) begin
                        if ({r_min_t, r_min_o} == 8'h99) begin
                            w_min_t_nxt = 4'd0;
                            w_min_o_nxt = 4'd0;
                        end else if (r_min_o == 4'd9) begin
                            w_min_t_nxt = r_min_t + 4'd1;
                            w_min_o_nxt = 4'd0;
                        end else begin
                            w_min_o_nxt = r_min_o + 4'd1;
                        end
                    end
                    if (btn_sec) begin
                        if ({r_sec_t, r_sec_o} == 8'h59) begin
                            w_sec_t_nxt = 4'd0;
                            w_sec_o_nxt = 4'd0;
                        end else if (r_sec_o == 4'd9) begin
                            w_sec_t_nxt = r_sec_t + 4'd1;
                            w_sec_o_nxt = 4'd0;
                        end else begin
                            w_sec_o_nxt = r_sec_o + 4'd1;
                        end
                    end
                end
                c_st_run: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if ({r_sec_t, r_sec_o} != 8'h00) begin
                            if (r_sec_o == 4'd0) begin
                                w_sec_t_nxt = r_sec_t - 4'd1;
                                w_sec_o_nxt = 4'd9;
                            end else begin
                                w_sec_o_nxt = r_sec_o - 4'd1;
                            end
                        end else if ({r_min_t, r_min_o} != 8'h00) begin
                            w_sec_t_nxt = 4'd5;
                            w_sec_o_nxt = 4'd9;
                            if (r_min_o == 4'd0) begin
                                w_min_t_nxt = r_min_t - 4'd1;
                                w_min_o_nxt = 4'd9;
                            end else begin
                                w_min_o_nxt = r_min_o - 4'd1;
                            end
                        end
                    end
                end
                c_st_done: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    w_min_t_nxt = 4'd0;
                    w_min_o_nxt = 4'd0;
                    w_sec_t_nxt = 4'd0;
                    w_sec_o_nxt = 4'd0;
                    if (w_state_nxt == c_st_done)
                        w_acnt_nxt = w_tick ? r_acnt + 1'b1 : r_acnt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_min_t <= 4'd0;
            r_min_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_o <= 4'd0;
            r_presc <= '0;
            r_acnt  <= '0;
        end else begin
            r_min_t <= w_min_t_nxt;
            r_min_o <= w_min_o_nxt;
            r_sec_t <= w_sec_t_nxt;
            r_sec_o <= w_sec_o_nxt;
            r_presc <= w_presc_nxt;
            r_acnt  <= w_acnt_nxt;
        end
    end

`ifdef KTIMER_BLINK_EN
    logic r_blink;

    // Phase is forced low outside DONE so every DONE entry starts visible
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink <= 1'b0;
        end else if (btn_clear || (r_state != c_st_done) || (w_state_nxt != c_st_done)) begin
            r_blink <= 1'b0;
        end else if (w_tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign w_blank = r_blink;
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            c1 <= 7'b1000000;
            c2 <= 7'b1000000;
            c3 <= 7'b1000000;
            c4 <= 7'b1000000;
        end else begin
            c1 <= w_blank ? c_seg_blank : seg_encode(r_min_t);
            c2 <= w_blank ? c_seg_blank : seg_encode(r_min_o);
            c3 <= w_blank ? c_seg_blank : seg_encode(r_sec_t);
            c4 <= w_blank ? c_seg_blank : seg_encode(r_sec_o);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kitchen_timer_ctrl.sv
// ============================================================================
//  Module   : tb_kitchen_timer_ctrl
//  Brief    : Directed self-checking bench for kitchen_timer_ctrl
//             (TICK_DIV=4, ALARM_SECS=2; honours KTIMER_BLINK_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_kitchen_timer_ctrl;

    localparam logic [6:0] c_s0 = 7'b1000000;
    localparam logic [6:0] c_s1 = 7'b1111001;
    localparam logic [6:0] c_s3 = 7'b0110000;
    localparam logic [6:0] c_s4 = 7'b0011001;
    localparam logic [6:0] c_s5 = 7'b0010010;
    localparam logic [6:0] c_s9 = 7'b0010000;
    localparam logic [6:0] c_bl = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic [6:0] c1, c2, c3, c4;
    logic       alarm, running;

    int n_tests = 0;
    int n_fail  = 0;

    kitchen_timer_ctrl #(
        .TICK_DIV   (4),
        .ALARM_SECS (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_min   (btn_min),
        .btn_sec   (btn_sec),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .alarm     (alarm),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] disp(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c, input logic [6:0] d);
        return {4'h0, a, b, c, d};
    endfunction

    // Called at a negedge: the pulse is sampled on the next posedge,
    // and the task returns at the following negedge.
    task automatic pulse(input logic s, input logic c, input logic m, input logic sc);
        btn_start = s;
        btn_clear = c;
        btn_min   = m;
        btn_sec   = sc;
        @(negedge clk);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_min   = 1'b0;
        btn_sec   = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        wait_neg(2);
        check("reset_disp", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s0));
        check("reset_alarm", {31'd0, alarm}, 32'd0);
        check("reset_running", {31'd0, running}, 32'd0);
        reset = 1'b0;

        // Start at 00:00 is ignored
        pulse(1, 0, 0, 0);
        check("start_at_zero", {31'd0, running}, 32'd0);

        // Set 01:03, then wrap seconds back to 00 with no carry
        pulse(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) pulse(0, 0, 0, 1);
        wait_neg(1);
        check("set_0103", disp(c1, c2, c3, c4), disp(c_s0, c_s1, c_s0, c_s3));
        for (int i = 0; i < 57; i++) pulse(0, 0, 0, 1);
        wait_neg(1);
        check("sec_wrap", disp(c1, c2, c3, c4), disp(c_s0, c_s1, c_s0, c_s0));

        // Borrow and DONE from 01:00
        pulse(1, 0, 0, 0);                      // sampled E0, now E0+0.5
        check("run_started", {31'd0, running}, 32'd1);
        wait_neg(4);                            // E0+4.5
        check("before_tick", disp(c1, c2, c3, c4), disp(c_s0, c_s1, c_s0, c_s0));
        wait_neg(1);                            // E0+5.5
        check("borrow_0059", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s5, c_s9));
        wait_neg(234);                          // E0+239.5
        check("not_done_yet", {31'd0, alarm}, 32'd0);
        wait_neg(1);                            // E0+240.5
        check("done_alarm", {30'd0, alarm, running}, 32'd2);
        wait_neg(1);                            // E0+241.5
        check("done_disp", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s0));
        wait_neg(2);                            // E0+243.5
        check("done_phase0", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s0));
        wait_neg(4);                            // E0+247.5
`ifdef KTIMER_BLINK_EN
        check("done_phase1", disp(c1, c2, c3, c4), disp(c_bl, c_bl, c_bl, c_bl));
`else
        check("done_steady", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s0));
`endif
        check("alarm_held", {31'd0, alarm}, 32'd1);
        wait_neg(1);                            // E0+248.5
        check("auto_return", {30'd0, alarm, running}, 32'd0);
        wait_neg(1);
        check("auto_return_disp", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s0));

        // Pause/resume from 00:05
        for (int i = 0; i < 5; i++) pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);                      // E0 sampled, now E0+0.5
        wait_neg(1);
        pulse(1, 0, 0, 0);                      // pause sampled E0+2
        check("paused", {31'd0, running}, 32'd0);
        pulse(0, 0, 1, 0);                      // ignored in PAUSE
        pulse(0, 0, 0, 1);
        wait_neg(18);                           // E0+22.5
        check("pause_hold", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s5));
        pulse(1, 0, 0, 0);                      // resume sampled E0+23
        check("resumed", {31'd0, running}, 32'd1);
        wait_neg(2);                            // E0+25.5
        check("resume_pre", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s5));
        wait_neg(1);                            // E0+26.5
        check("resume_dec", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s4));

        // Clear + start on a tick cycle (next tick at E0+29)
        wait_neg(2);
        pulse(1, 1, 0, 0);
        check("clear_state", {30'd0, alarm, running}, 32'd0);
        wait_neg(1);
        check("clear_disp", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s0));

        // DONE acknowledged by btn_start
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        wait_neg(4);
        check("done_from_0001", {30'd0, alarm, running}, 32'd2);
        pulse(1, 0, 0, 0);
        check("ack_state", {30'd0, alarm, running}, 32'd0);

        // Minutes wrap 99 -> 00
        for (int i = 0; i < 99; i++) pulse(0, 0, 1, 0);
        wait_neg(1);
        check("min_99", disp(c1, c2, c3, c4), disp(c_s9, c_s9, c_s0, c_s0));
        pulse(0, 0, 1, 1);
        wait_neg(1);
        check("min_wrap_both", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s1));

        // Reset while running
        pulse(1, 0, 0, 0);
        wait_neg(2);
        reset = 1'b1;
        wait_neg(1);
        reset = 1'b0;
        check("midreset_state", {30'd0, alarm, running}, 32'd0);
        check("midreset_disp", disp(c1, c2, c3, c4), disp(c_s0, c_s0, c_s0, c_s0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
